hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/fwd_unit.sv | 24 ++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline record, forwarding select and match helper
package riscv_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_wr;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } stage_rec_t;

  // A record produces addr only if it is a live write to a real register; x0 never matches.
  function automatic logic rec_writes(input stage_rec_t r, input logic [REG_ADDR_W-1:0] addr);
    return r.valid && r.rd_wr && (r.rd != '0) && (r.rd == addr);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - operand forwarding select for one EX source register
module fwd_unit
  import riscv_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  stage_rec_t            mem_rec,
  input  stage_rec_t            wb_rec,
  output fwd_sel_e              sel
);

  logic unused_fields;
  assign unused_fields = ^{mem_rec.rs1, mem_rec.rs2, wb_rec.is_load, wb_rec.rs1, wb_rec.rs2};

  // A load in MEM has no data yet, so it falls through to the older WB producer.
  always_comb begin
    sel = FWD_RF;
    if (rec_writes(mem_rec, rs) && !mem_rec.is_load) begin
      sel = FWD_EXMEM;
    end else if (rec_writes(wb_rec, rs)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline stall, flush and forwarding control
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_rd_wr,
  input  logic                  id_is_load,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  import riscv_pkg::*;

  stage_rec_t id_rec, ex_rec, mem_rec, wb_rec;
  fwd_sel_e   fwd_a, fwd_b;
  logic       load_use;

  always_comb begin
    id_rec         = '0;
    id_rec.valid   = id_valid;
    id_rec.rd      = id_rd;
    id_rec.rd_wr   = id_rd_wr;
    id_rec.is_load = id_is_load;
    id_rec.rs1     = id_rs1;
    id_rec.rs2     = id_rs2;
  end

  assign load_use = id_valid && ex_rec.is_load &&
                    ((id_uses_rs1 && rec_writes(ex_rec, id_rs1)) ||
                     (id_uses_rs2 && rec_writes(ex_rec, id_rs2)));

  always_comb begin
    pc_inc       = 1'b1;
    pc_load      = 1'b0;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (mem_busy) begin
      pc_inc    = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (ex_branch_taken) begin
      pc_inc       = 1'b0;
      pc_load      = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      // Hold IF/ID one cycle; the bubble lets the load reach MEM before its consumer enters EX.
      pc_inc       = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  fwd_unit u_fwd_a (
    .rs      (ex_rec.rs1),
    .mem_rec (mem_rec),
    .wb_rec  (wb_rec),
    .sel     (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs      (ex_rec.rs2),
    .mem_rec (mem_rec),
    .wb_rec  (wb_rec),
    .sel     (fwd_b)
  );

  assign fwd_a_sel = fwd_a;
  assign fwd_b_sel = fwd_b;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_rec    <= '0;
      mem_rec   <= '0;
      wb_rec    <= '0;
      stall_cnt <= '0;
    end else begin
      if (mem_wb_en) wb_rec  <= mem_rec;
      if (ex_mem_en) mem_rec <= ex_rec;
      if (id_ex_en)  ex_rec  <= id_ex_bubble ? '0 : id_rec;
      if (!if_id_en && stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector table plus randomized model check of hazard_ctrl
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_uses_rs1, id_uses_rs2, id_rd_wr, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_branch_taken, mem_busy;

  logic        pc_inc, pc_load, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt;

  logic        pc_inc_4, pc_load_4, if_id_en_4, id_ex_en_4, ex_mem_en_4, mem_wb_en_4;
  logic        if_id_flush_4, id_ex_bubble_4;
  logic [1:0]  fwd_a_sel_4, fwd_b_sel_4;
  logic [3:0]  stall_cnt_4;

  hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_rd_wr(id_rd_wr), .id_is_load(id_is_load),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_inc(pc_inc), .pc_load(pc_load), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_rd_wr(id_rd_wr), .id_is_load(id_is_load),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_inc(pc_inc_4), .pc_load(pc_load_4), .if_id_en(if_id_en_4), .id_ex_en(id_ex_en_4),
    .ex_mem_en(ex_mem_en_4), .mem_wb_en(mem_wb_en_4), .if_id_flush(if_id_flush_4),
    .id_ex_bubble(id_ex_bubble_4), .fwd_a_sel(fwd_a_sel_4), .fwd_b_sel(fwd_b_sel_4),
    .stall_cnt(stall_cnt_4)
  );

  // Control vector order: pc_inc pc_load if_id_en id_ex_en ex_mem_en mem_wb_en if_id_flush id_ex_bubble
  localparam logic [7:0] NORM = 8'b1011_1100;
  localparam logic [7:0] LU   = 8'b0001_1101;
  localparam logic [7:0] BR   = 8'b0111_1111;
  localparam logic [7:0] BUSY = 8'b0000_0000;

  typedef struct {
    bit rst, v, u1, u2, wr, ld;
    int rs1, rs2, rd;
    bit br, busy;
    logic [7:0] ctl;
    int fa, fb, cnt;
  } vec_t;

  typedef struct {
    bit v, wr, ld;
    int rd, rs1, rs2;
  } mrec_t;

  int    n_chk = 0;
  int    n_fail = 0;
  vec_t  tbl[$];
  mrec_t pipe[3];
  int    m_cnt16 = 0;
  int    m_cnt4 = 0;

  function automatic vec_t mk(bit r, bit v, bit u1, bit u2, bit wr, bit ld, int rs1, int rs2, int rd,
                              bit br, bit busy, logic [7:0] ctl, int fa, int fb, int cnt);
    vec_t x;
    x.rst = r; x.v = v; x.u1 = u1; x.u2 = u2; x.wr = wr; x.ld = ld;
    x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.br = br; x.busy = busy;
    x.ctl = ctl; x.fa = fa; x.fb = fb; x.cnt = cnt;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit hit(mrec_t r, int a);
    return r.v && r.wr && r.rd != 0 && r.rd == a;
  endfunction

  // 3 = frozen, 2 = redirect, 1 = load-use, 0 = normal
  function automatic int m_mode();
    bit lu;
    lu = id_valid && pipe[0].ld &&
         ((id_uses_rs1 && hit(pipe[0], int'(id_rs1))) || (id_uses_rs2 && hit(pipe[0], int'(id_rs2))));
    if (mem_busy) return 3;
    if (ex_branch_taken) return 2;
    if (lu) return 1;
    return 0;
  endfunction

  function automatic logic [7:0] m_ctl();
    case (m_mode())
      3: return BUSY;
      2: return BR;
      1: return LU;
      default: return NORM;
    endcase
  endfunction

  function automatic int m_fwd(int a);
    if (hit(pipe[1], a) && !pipe[1].ld) return 1;
    if (hit(pipe[2], a)) return 2;
    return 0;
  endfunction

  task automatic model_edge();
    int    mode;
    mrec_t empty, nxt;
    empty = '{default: 0};
    if (!rst) begin
      pipe[0] = empty; pipe[1] = empty; pipe[2] = empty;
      m_cnt16 = 0; m_cnt4 = 0;
    end else begin
      mode = m_mode();
      if (mode == 3 || mode == 1) begin
        m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
        m_cnt4  = (m_cnt4 == 15) ? 15 : m_cnt4 + 1;
      end
      if (mode != 3) begin
        nxt.v = id_valid; nxt.wr = id_rd_wr; nxt.ld = id_is_load;
        nxt.rd = int'(id_rd); nxt.rs1 = int'(id_rs1); nxt.rs2 = int'(id_rs2);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (mode == 0) ? nxt : empty;
      end
    end
  endtask

  task automatic apply(input vec_t r);
    rst = r.rst; id_valid = r.v; id_uses_rs1 = r.u1; id_uses_rs2 = r.u2;
    id_rd_wr = r.wr; id_is_load = r.ld;
    id_rs1 = 5'(r.rs1); id_rs2 = 5'(r.rs2); id_rd = 5'(r.rd);
    ex_branch_taken = r.br; mem_busy = r.busy;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic int act_ctl();
    return int'({pc_inc, pc_load, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble});
  endfunction

  initial begin
    vec_t idle, r;
    idle = mk(1, 0,0,0,0,0, 0,0,0, 0,0, NORM,0,0,0);

    tbl.push_back(idle);                                               // post-reset idle
    tbl.push_back(mk(1, 1,1,0,1,1, 1,0,5,  0,0, NORM,0,0,0));          // lw x5
    tbl.push_back(mk(1, 1,1,1,1,0, 5,7,6,  0,0, LU,  0,0,0));          // add x6,x5,x7 stalls
    tbl.push_back(mk(1, 1,1,1,1,0, 5,7,6,  0,0, NORM,0,0,1));
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,  0,0, NORM,2,0,1));          // WB forward of load
    tbl.push_back(mk(1, 1,1,0,1,0, 1,0,5,  0,0, NORM,0,0,1));          // add x5 (older)
    tbl.push_back(mk(1, 1,1,0,1,0, 2,0,5,  0,0, NORM,0,0,1));          // add x5 (younger)
    tbl.push_back(mk(1, 1,1,1,1,0, 5,9,10, 0,0, NORM,0,0,1));          // reader x5, x9
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,  0,0, NORM,1,0,1));          // MEM beats WB
    tbl.push_back(mk(1, 1,0,0,1,0, 0,0,9,  0,0, NORM,0,0,1));          // add x9
    tbl.push_back(mk(1, 1,0,0,1,0, 0,0,3,  0,0, NORM,0,0,1));
    tbl.push_back(mk(1, 1,0,1,1,0, 0,9,11, 0,0, NORM,0,0,1));          // reader rs2=x9
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,  0,0, NORM,0,2,1));          // WB-only match
    tbl.push_back(mk(1, 1,0,0,1,1, 0,0,0,  0,0, NORM,0,0,1));          // lw x0
    tbl.push_back(mk(1, 1,1,1,1,0, 0,0,12, 0,0, NORM,0,0,1));          // reader x0: no stall
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,  0,0, NORM,0,0,1));
    tbl.push_back(mk(1, 1,0,0,1,1, 0,0,8,  0,0, NORM,0,0,1));          // lw x8
    tbl.push_back(mk(1, 1,1,0,1,0, 8,0,13, 1,0, BR,  0,0,1));          // branch beats load-use
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,  0,0, NORM,0,0,1));
    tbl.push_back(mk(1, 1,0,0,1,1, 0,0,4,  0,0, NORM,0,0,1));          // lw x4
    tbl.push_back(mk(1, 1,0,1,1,0, 0,4,14, 0,1, BUSY,0,0,1));          // busy during load-use
    tbl.push_back(mk(1, 1,0,1,1,0, 0,4,14, 0,1, BUSY,0,0,2));
    tbl.push_back(mk(1, 1,0,1,1,0, 0,4,14, 0,1, BUSY,0,0,3));
    tbl.push_back(mk(1, 1,0,1,1,0, 0,4,14, 0,0, LU,  0,0,4));
    tbl.push_back(mk(1, 1,0,1,1,0, 0,4,14, 0,0, NORM,0,0,5));
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,  0,0, NORM,0,2,5));
    tbl.push_back(mk(1, 1,0,0,1,1, 0,0,2,  0,0, NORM,0,0,5));          // lw x2
    tbl.push_back(mk(0, 1,1,0,1,0, 2,0,15, 0,0, LU,  0,0,5));          // reset mid-stall
    tbl.push_back(mk(1, 1,1,0,1,0, 2,0,15, 0,0, NORM,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,  0,0, NORM,0,0,0));
    tbl.push_back(mk(0, 1,0,0,1,1, 0,0,3,  1,1, BUSY,0,0,0));          // reset beats busy+branch
    tbl.push_back(idle);

    apply(mk(0, 0,0,0,0,0, 0,0,0, 0,0, NORM,0,0,0));
    clock_edge();
    clock_edge();

    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("tbl%0d_ctl", i), act_ctl(), int'(tbl[i].ctl));
      chk($sformatf("tbl%0d_fwd_a", i), int'(fwd_a_sel), tbl[i].fa);
      chk($sformatf("tbl%0d_fwd_b", i), int'(fwd_b_sel), tbl[i].fb);
      chk($sformatf("tbl%0d_stall_cnt", i), int'(stall_cnt), tbl[i].cnt);
      chk($sformatf("tbl%0d_stall_cnt_w4", i), int'(stall_cnt_4), tbl[i].cnt);
      clock_edge();
    end

    // Narrow counter saturates instead of wrapping.
    r = idle; r.rst = 0;
    apply(r);
    clock_edge();
    r = idle; r.busy = 1;
    apply(r);
    for (int k = 0; k < 20; k++) clock_edge();
    @(negedge clk);
    chk("sat_w4", int'(stall_cnt_4), 15);
    chk("sat_w16", int'(stall_cnt), 20);
    clock_edge();

    for (int k = 0; k < 400; k++) begin
      r.rst  = ($urandom_range(0, 49) != 0);
      r.v    = $urandom_range(0, 3) != 0;
      r.u1   = $urandom_range(0, 1);
      r.u2   = $urandom_range(0, 1);
      r.wr   = $urandom_range(0, 3) != 0;
      r.ld   = $urandom_range(0, 2) == 0;
      r.rs1  = $urandom_range(0, 3);
      r.rs2  = $urandom_range(0, 3);
      r.rd   = $urandom_range(0, 3);
      r.br   = $urandom_range(0, 7) == 0;
      r.busy = $urandom_range(0, 4) == 0;
      apply(r);
      @(negedge clk);
      chk($sformatf("rnd%0d_ctl", k), act_ctl(), int'(m_ctl()));
      chk($sformatf("rnd%0d_fwd_a", k), int'(fwd_a_sel), m_fwd(pipe[0].rs1));
      chk($sformatf("rnd%0d_fwd_b", k), int'(fwd_b_sel), m_fwd(pipe[0].rs2));
      chk($sformatf("rnd%0d_stall_cnt", k), int'(stall_cnt), m_cnt16);
      chk($sformatf("rnd%0d_stall_cnt_w4", k), int'(stall_cnt_4), m_cnt4);
      clock_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
